// File: rtl/fcoe_crc_pkg.sv
// fcoe_crc_pkg
//   Shared constants, FSM state type and the 32-bit CRC step for the FCoE CRC-32 frame
//   controller. The CRC is the reflected Ethernet/FC CRC-32: data enters LSB of byte0 first.
package fcoe_crc_pkg;

    localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
    // Reflected polynomial, as used by the LSB-first shift register.
    localparam logic [31:0] CRC_POLY_R  = {<<{CRC_POLY}};
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_XOROUT  = 32'hFFFF_FFFF;
    // Register contents after running a frame plus its own correct FCS through the CRC.
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    typedef enum logic [1:0] {
        IDLE,
        FRAME,
        TAIL
    } crc_state_e;

    // Advance the CRC register by one full 32-bit word (byte0 in [7:0] first).
    // XORing the whole word up front is equivalent to feeding bit i in at step i.
    function automatic logic [31:0] crc32_step32(input logic [31:0] state,
                                                 input logic [31:0] data);
        logic [31:0] c;
        c = state ^ data;
        for (int i = 0; i < 32; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_R) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/fcoe_crc_frame_ctrl_if.sv
// fcoe_crc_frame_ctrl_if
//   MAC-side word stream into the CRC frame controller.
//   s_valid/s_ready : beat handshake, beat taken when both are high
//   s_data          : 4 frame bytes, byte0 (first on wire) in [7:0]
//   s_sof/s_eof     : first / last beat of a frame
//   s_nbytes        : valid low bytes on the eof beat, 0 means all 4
//   check_en        : frame mode, sampled on the sof beat (1 = check FCS, 0 = generate)
//   master drives the stream, slave (the controller) returns s_ready.
interface fcoe_crc_frame_ctrl_if;

    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_sof;
    logic        s_eof;
    logic [1:0]  s_nbytes;
    logic        check_en;

    modport master (
        output s_valid, s_data, s_sof, s_eof, s_nbytes, check_en,
        input  s_ready
    );

    modport slave (
        input  s_valid, s_data, s_sof, s_eof, s_nbytes, check_en,
        output s_ready
    );

endinterface

// File: rtl/fcoe_crc_byte_step.sv
// fcoe_crc_byte_step
//   Combinational single-byte advance of the reflected CRC-32 register, used to drain the
//   1..3 trailing bytes of a frame.
//   state      in  32  current CRC register
//   data       in  8   next byte, bit0 enters first
//   next_state out 32  CRC register after the byte
module fcoe_crc_byte_step
    import fcoe_crc_pkg::*;
(
    input  logic [31:0] state,
    input  logic [7:0]  data,
    output logic [31:0] next_state
);

    always_comb begin
        next_state = state ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            next_state = next_state[0] ? ((next_state >> 1) ^ CRC_POLY_R) : (next_state >> 1);
        end
    end

endmodule

// File: rtl/fcoe_crc_frame_ctrl.sv
// fcoe_crc_frame_ctrl
//   Runs the FCoE CRC-32 over a framed 32-bit word stream, one frame at a time. Whole words
//   step through the 32-bit equations; a partial last word is drained one byte per cycle
//   while s_ready is held low. At frame end it reports the FCS (generate mode) or whether
//   the stream carried a correct FCS (check mode).
//   clk, rst   single clock, synchronous active-high reset
//   strm       input word stream (slave side)
//   res_valid  one-cycle result strobe; res_crc/res_ok/res_len hold until the next one
//   res_crc    FCS value (~CRC register), FCS byte0 in [7:0]
//   res_ok     check mode only: final register equals the CRC residue
//   res_len    frame length in bytes, saturating at all-ones
//   res_abort  one-cycle strobe when a new sof abandons a frame in progress
module fcoe_crc_frame_ctrl
    import fcoe_crc_pkg::*;
#(
    parameter int unsigned LEN_W     = 16,
    parameter bit          CHECK_DEF = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    fcoe_crc_frame_ctrl_if.slave strm,
    output logic                 res_valid,
    output logic [31:0]          res_crc,
    output logic                 res_ok,
    output logic [LEN_W-1:0]     res_len,
    output logic                 res_abort
);

    crc_state_e       state_q;
    logic [31:0]      crc_q;
    logic [31:0]      tail_q;
    logic [1:0]       tail_cnt_q;
    logic [LEN_W-1:0] len_q;
    logic             mode_q;

    logic             accept;
    logic             take;
    logic             frame_mode;
    logic [31:0]      seed;
    logic [31:0]      word_crc;
    logic [31:0]      byte_crc;
    logic [2:0]       beat_bytes;
    logic [LEN_W-1:0] len_base;
    logic [LEN_W:0]   len_sum;
    logic [LEN_W-1:0] len_next;

    assign strm.s_ready = (state_q != TAIL);
    assign accept       = strm.s_valid & strm.s_ready;
    // Outside a frame only a sof beat means anything; other beats are swallowed.
    assign take         = accept & (strm.s_sof | (state_q == FRAME));
    assign seed         = (strm.s_sof | (state_q != FRAME)) ? CRC_INIT : crc_q;
    assign word_crc     = crc32_step32(seed, strm.s_data);
    assign frame_mode   = strm.s_sof ? strm.check_en : mode_q;

    // Bytes carried by this beat and the saturating running length.
    assign beat_bytes = (strm.s_eof && (strm.s_nbytes != 2'd0)) ? {1'b0, strm.s_nbytes} : 3'd4;
    assign len_base   = strm.s_sof ? '0 : len_q;
    assign len_sum    = {1'b0, len_base} + {{(LEN_W - 2){1'b0}}, beat_bytes};
    assign len_next   = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];

    fcoe_crc_byte_step u_byte_step (
        .state      (crc_q),
        .data       (tail_q[7:0]),
        .next_state (byte_crc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            crc_q      <= CRC_INIT;
            tail_q     <= '0;
            tail_cnt_q <= '0;
            len_q      <= '0;
            mode_q     <= CHECK_DEF;
            res_valid  <= 1'b0;
            res_crc    <= '0;
            res_ok     <= 1'b0;
            res_len    <= '0;
            res_abort  <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            res_abort <= 1'b0;
            case (state_q)
                IDLE, FRAME: begin
                    if (take) begin
                        mode_q    <= frame_mode;
                        len_q     <= len_next;
                        res_abort <= strm.s_sof & (state_q == FRAME);
                        if (!strm.s_eof) begin
                            crc_q   <= word_crc;
                            state_q <= FRAME;
                        end else if (strm.s_nbytes == 2'd0) begin
                            crc_q     <= CRC_INIT;
                            state_q   <= IDLE;
                            res_valid <= 1'b1;
                            res_crc   <= word_crc ^ CRC_XOROUT;
                            res_ok    <= frame_mode & (word_crc == CRC_RESIDUE);
                            res_len   <= len_next;
                        end else begin
                            // Partial last word: park it and drain lowest byte first.
                            crc_q      <= seed;
                            tail_q     <= strm.s_data;
                            tail_cnt_q <= strm.s_nbytes;
                            state_q    <= TAIL;
                        end
                    end
                end
                TAIL: begin
                    crc_q      <= byte_crc;
                    tail_q     <= tail_q >> 8;
                    tail_cnt_q <= tail_cnt_q - 2'd1;
                    if (tail_cnt_q == 2'd1) begin
                        state_q   <= IDLE;
                        res_valid <= 1'b1;
                        res_crc   <= byte_crc ^ CRC_XOROUT;
                        res_ok    <= mode_q & (byte_crc == CRC_RESIDUE);
                        res_len   <= len_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fcoe_crc_frame_ctrl.sv
// tb_fcoe_crc_frame_ctrl
//   Drives two controllers (LEN_W=16 and LEN_W=4) with identical streams and scores their
//   results against a byte-level CRC-32 model.
module tb_fcoe_crc_frame_ctrl;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        int          cyc;
        logic [31:0] crc;
        logic        ok;
        int          len;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fcoe_crc_frame_ctrl_if if_a();
    fcoe_crc_frame_ctrl_if if_b();

    logic        res_valid_a, res_ok_a, res_abort_a;
    logic [31:0] res_crc_a;
    logic [15:0] res_len_a;
    logic        res_valid_b, res_ok_b, res_abort_b;
    logic [31:0] res_crc_b;
    logic [3:0]  res_len_b;

    fcoe_crc_frame_ctrl #(.LEN_W(16), .CHECK_DEF(1'b0)) dut_a (
        .clk(clk), .rst(rst), .strm(if_a), .res_valid(res_valid_a), .res_crc(res_crc_a),
        .res_ok(res_ok_a), .res_len(res_len_a), .res_abort(res_abort_a)
    );

    fcoe_crc_frame_ctrl #(.LEN_W(4), .CHECK_DEF(1'b0)) dut_b (
        .clk(clk), .rst(rst), .strm(if_b), .res_valid(res_valid_b), .res_crc(res_crc_b),
        .res_ok(res_ok_b), .res_len(res_len_b), .res_abort(res_abort_b)
    );

    res_t got_a[$], got_b[$], exp_q[$];
    int   abort_a[$], abort_b[$];
    res_t last_a, last_b;
    int   last_sof_acc;

    always @(negedge clk) begin
        if (res_valid_a) got_a.push_back('{cyc, res_crc_a, res_ok_a, int'(res_len_a)});
        if (res_valid_b) got_b.push_back('{cyc, res_crc_b, res_ok_b, int'(res_len_b)});
        if (res_abort_a) abort_a.push_back(cyc);
        if (res_abort_b) abort_b.push_back(cyc);
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_crc(input byte_q_t b);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (b[i]) begin
            c = c ^ {24'h0, b[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    // Check mode: the last four bytes must be the little-endian FCS of everything before.
    function automatic logic ok_model(input byte_q_t b, input logic chk);
        byte_q_t     p;
        logic [31:0] fcs;
        int          n;
        n = b.size();
        if (!chk || n < 4) return 1'b0;
        for (int i = 0; i < n - 4; i++) p.push_back(b[i]);
        fcs = {b[n-1], b[n-2], b[n-3], b[n-4]};
        return model_crc(p) == fcs;
    endfunction

    function automatic byte_q_t ascii_digits();
        byte_q_t b;
        for (int i = 0; i < 9; i++) b.push_back(8'h31 + 8'(i));
        return b;
    endfunction

    // ---------------- drivers ----------------
    task automatic set_in(input logic v, input logic [31:0] d, input logic sof, input logic eof,
                          input logic [1:0] nb, input logic chk);
        if_a.s_valid = v; if_a.s_data = d; if_a.s_sof = sof; if_a.s_eof = eof;
        if_a.s_nbytes = nb; if_a.check_en = chk;
        if_b.s_valid = v; if_b.s_data = d; if_b.s_sof = sof; if_b.s_eof = eof;
        if_b.s_nbytes = nb; if_b.check_en = chk;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic sof, input logic eof,
                             input logic [1:0] nb, input logic chk, output int acc);
        int guard;
        @(negedge clk);
        set_in(1'b1, d, sof, eof, nb, chk);
        guard = 0;
        while (!if_a.s_ready && guard < 16) begin
            @(negedge clk);
            guard++;
        end
        if (!if_a.s_ready) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: s_ready=%b, required 1 within 16 cycles", if_a.s_ready);
        end
        acc = cyc;
        @(posedge clk);
        #1;
        set_in(1'b0, 32'($urandom), 1'b0, 1'b0, 2'd0, 1'b0);
    endtask

    // Send a whole frame and queue the expected result. With watch set, also checks that
    // s_ready drops for exactly the tail byte count after the eof beat.
    task automatic send_frame(input byte_q_t b, input logic chk, input int gap_max,
                              input bit watch);
        int          n, nbeats, acc, k;
        logic [31:0] w;
        logic [1:0]  nb;
        res_t        e;
        n      = b.size();
        nbeats = (n + 3) / 4;
        k      = n % 4;
        acc    = 0;
        for (int i = 0; i < nbeats; i++) begin
            for (int j = 0; j < 4; j++)
                w[8*j +: 8] = (4 * i + j < n) ? b[4*i + j] : 8'($urandom);
            nb = (i == nbeats - 1) ? 2'(k) : 2'($urandom);
            if (i > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
            send_beat(w, i == 0, i == nbeats - 1, nb, (i == 0) ? chk : 1'($urandom), acc);
            if (i == 0) last_sof_acc = acc;
        end
        e.cyc = acc + k + 1;
        e.crc = model_crc(b);
        e.ok  = ok_model(b, chk);
        e.len = n;
        exp_q.push_back(e);
        if (watch) begin
            for (int i = 1; i <= k + 1; i++) begin
                @(negedge clk);
                checks++;
                if (if_a.s_ready !== (i > k)) begin
                    failures++;
                    $display("FAIL tail_ready: cycle T+%0d s_ready=%b, required %b",
                             i, if_a.s_ready, (i > k));
                end
            end
        end
    endtask

    task automatic check_results(input string tag);
        res_t e, ra, rb;
        int   guard;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            guard = 0;
            while ((got_a.size() == 0 || got_b.size() == 0) && guard < 40) begin
                @(posedge clk);
                guard++;
            end
            checks++;
            if (got_a.size() == 0 || got_b.size() == 0) begin
                failures++;
                $display("FAIL %s_timeout: no res_valid seen, required one at cycle %0d",
                         tag, e.cyc);
                exp_q.delete();
                break;
            end
            ra = got_a.pop_front();
            rb = got_b.pop_front();
            last_a = ra;
            last_b = rb;
            checks++;
            if (ra.cyc !== e.cyc || rb.cyc !== e.cyc) begin
                failures++;
                $display("FAIL %s_latency: res_valid at cycles %0d/%0d, required %0d",
                         tag, ra.cyc, rb.cyc, e.cyc);
            end
            checks++;
            if (ra.crc !== e.crc || rb.crc !== e.crc) begin
                failures++;
                $display("FAIL %s_crc: got %h/%h, required %h", tag, ra.crc, rb.crc, e.crc);
            end
            checks++;
            if (ra.ok !== e.ok || rb.ok !== e.ok) begin
                failures++;
                $display("FAIL %s_ok: got %b/%b, required %b", tag, ra.ok, rb.ok, e.ok);
            end
            checks++;
            if (ra.len !== ((e.len > 65535) ? 65535 : e.len)) begin
                failures++;
                $display("FAIL %s_len16: got %0d, required %0d", tag, ra.len, e.len);
            end
            checks++;
            if (rb.len !== ((e.len > 15) ? 15 : e.len)) begin
                failures++;
                $display("FAIL %s_len4: got %0d, required %0d", tag, rb.len,
                         (e.len > 15) ? 15 : e.len);
            end
        end
        repeat (4) @(posedge clk);
        checks++;
        if (got_a.size() != 0 || got_b.size() != 0) begin
            failures++;
            $display("FAIL %s_extra: %0d/%0d unexpected res_valid pulses, required 0",
                     tag, got_a.size(), got_b.size());
            got_a.delete();
            got_b.delete();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (if_a.s_ready !== 1'b1 || res_valid_a !== 1'b0 || res_abort_a !== 1'b0 ||
            res_ok_a !== 1'b0 || res_crc_a !== 32'h0 || res_len_a !== 16'h0) begin
            failures++;
            $display("FAIL reset: ready=%b valid=%b abort=%b ok=%b crc=%h len=%0d, required 1 0 0 0 0 0",
                     if_a.s_ready, res_valid_a, res_abort_a, res_ok_a, res_crc_a, res_len_a);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_generate();
        send_frame(ascii_digits(), 1'b0, 0, 1'b1);
        check_results("gen");
        checks++;
        if (last_a.crc !== 32'hCBF4_3926 || last_a.len !== 9) begin
            failures++;
            $display("FAIL gen_vector: crc=%h len=%0d, required cbf43926 9", last_a.crc, last_a.len);
        end
    endtask

    task automatic test_check();
        byte_q_t b;
        b = ascii_digits();
        b.push_back(8'h26); b.push_back(8'h39); b.push_back(8'hF4); b.push_back(8'hCB);
        send_frame(b, 1'b1, 1, 1'b1);
        check_results("check_good");
        checks++;
        if (last_a.ok !== 1'b1 || last_a.len !== 13) begin
            failures++;
            $display("FAIL check_good_vector: ok=%b len=%0d, required 1 13", last_a.ok, last_a.len);
        end
        b[12] = 8'hCA;
        send_frame(b, 1'b1, 1, 1'b1);
        check_results("check_bad");
        checks++;
        if (last_a.ok !== 1'b0) begin
            failures++;
            $display("FAIL check_bad_vector: ok=%b, required 0", last_a.ok);
        end
    endtask

    task automatic test_single_beat();
        byte_q_t b;
        for (int i = 0; i < 4; i++) b.push_back(8'h00);
        send_frame(b, 1'b0, 0, 1'b1);
        check_results("single");
        checks++;
        if (last_a.crc !== 32'h2144_DF1C || last_a.len !== 4) begin
            failures++;
            $display("FAIL single_vector: crc=%h len=%0d, required 2144df1c 4", last_a.crc, last_a.len);
        end
    endtask

    task automatic test_reset_in_tail();
        int acc;
        send_beat(32'h1122_3344, 1'b1, 1'b0, 2'd0, 1'b0, acc);
        send_beat(32'h00AA_BBCC, 1'b0, 1'b1, 2'd3, 1'b0, acc);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (if_a.s_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_tail_ready: s_ready=%b, required 1", if_a.s_ready);
        end
        repeat (6) @(posedge clk);
        checks++;
        if (got_a.size() != 0 || got_b.size() != 0 || abort_a.size() != 0) begin
            failures++;
            $display("FAIL rst_tail_result: %0d res_valid, %0d res_abort, required 0 0",
                     got_a.size(), abort_a.size());
            got_a.delete();
            got_b.delete();
            abort_a.delete();
        end
        send_frame(ascii_digits(), 1'b0, 0, 1'b1);
        check_results("after_rst");
        checks++;
        if (last_a.crc !== 32'hCBF4_3926) begin
            failures++;
            $display("FAIL after_rst_vector: crc=%h, required cbf43926", last_a.crc);
        end
    endtask

    task automatic test_abort();
        int acc;
        abort_a.delete();
        abort_b.delete();
        send_beat(32'hDEAD_BEEF, 1'b1, 1'b0, 2'd0, 1'b1, acc);
        send_beat(32'h0BAD_F00D, 1'b0, 1'b0, 2'd0, 1'b1, acc);
        send_frame(ascii_digits(), 1'b0, 0, 1'b1);
        check_results("abort");
        checks++;
        if (last_a.crc !== 32'hCBF4_3926) begin
            failures++;
            $display("FAIL abort_vector: crc=%h, required cbf43926", last_a.crc);
        end
        checks++;
        if (abort_a.size() != 1 || abort_b.size() != 1) begin
            failures++;
            $display("FAIL abort_count: %0d/%0d pulses, required 1", abort_a.size(), abort_b.size());
        end else if (abort_a[0] != last_sof_acc + 1 || abort_b[0] != last_sof_acc + 1) begin
            failures++;
            $display("FAIL abort_cycle: at %0d/%0d, required %0d",
                     abort_a[0], abort_b[0], last_sof_acc + 1);
        end
        abort_a.delete();
        abort_b.delete();
    endtask

    task automatic test_saturation();
        byte_q_t b;
        for (int i = 0; i < 20; i++) b.push_back(8'($urandom));
        send_frame(b, 1'b0, 1, 1'b1);
        check_results("sat");
        checks++;
        if (last_b.len !== 15 || last_a.len !== 20) begin
            failures++;
            $display("FAIL sat_len: len4=%0d len16=%0d, required 15 20", last_b.len, last_a.len);
        end
    endtask

    task automatic test_back_to_back();
        byte_q_t b;
        int      res_cyc;
        send_frame(ascii_digits(), 1'b0, 0, 1'b0);
        res_cyc = exp_q[exp_q.size() - 1].cyc;
        for (int i = 0; i < 12; i++) b.push_back(8'($urandom));
        send_frame(b, 1'b0, 0, 1'b0);
        checks++;
        if (last_sof_acc != res_cyc) begin
            failures++;
            $display("FAIL b2b_sof: sof accepted at cycle %0d, required %0d", last_sof_acc, res_cyc);
        end
        check_results("b2b");
    endtask

    task automatic test_random();
        byte_q_t     b;
        logic        chk;
        int          n, idx;
        logic [31:0] fcs;
        for (int f = 0; f < 40; f++) begin
            b.delete();
            chk = 1'($urandom);
            n = $urandom_range(1, 30);
            for (int i = 0; i < n; i++) b.push_back(8'($urandom));
            if (chk) begin
                fcs = model_crc(b);
                for (int j = 0; j < 4; j++) b.push_back(fcs[8*j +: 8]);
                if ($urandom_range(0, 1) == 1) begin
                    idx = $urandom_range(0, b.size() - 1);
                    b[idx] = b[idx] ^ 8'(1 << $urandom_range(0, 7));
                end
            end
            send_frame(b, chk, 2, 1'b1);
            check_results("random");
        end
        checks++;
        if (abort_a.size() != 0 || abort_b.size() != 0) begin
            failures++;
            $display("FAIL random_abort: %0d spurious res_abort pulses, required 0", abort_a.size());
        end
    endtask

    initial begin
        test_reset();
        test_generate();
        test_check();
        test_single_beat();
        test_reset_in_tail();
        test_abort();
        test_saturation();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
